// File: rtl/epochtv1_pkg.sv
// Shared types and render-window defaults for the Epoch TV-1 video core.
package epochtv1_pkg;

  localparam logic [8:0] FIRST_ROW_RENDER_DEF = 9'd21;
  localparam logic [8:0] NUM_RENDER_ROWS_DEF  = 9'd222;
  localparam logic [8:0] FIRST_COL_RENDER_DEF = 9'd28;
  localparam logic [8:0] NUM_RENDER_COLS_DEF  = 9'd192;
  localparam logic [8:0] FETCH_LEAD           = 9'd8;

  typedef enum logic [2:0] {
    IDLE,
    MAP,
    CHR,
    LATCH,
    WAIT
  } bgFetchState_e;

  typedef struct packed {
    logic       sel;
    logic [6:0] code;
  } bgmEntry_t;

  function automatic logic [3:0] pickColour(input logic pixBit, input logic sel,
                                            input logic [3:0] fgA, input logic [3:0] fgB,
                                            input logic [3:0] bg);
    if (!pixBit) return bg;
    return sel ? fgB : fgA;
  endfunction

endpackage

// File: rtl/epochtv1_bg_sreg.sv
// Background pattern shift register with per-tile colour select and registered pixel output.
module epochtv1_bg_sreg
  import epochtv1_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce_i,
  input  logic       load_i,
  input  logic [7:0] pattern_i,
  input  logic       sel_i,
  input  logic       shift_i,
  input  logic       bgEn_i,
  input  logic [3:0] fgA_i,
  input  logic [3:0] fgB_i,
  input  logic [3:0] bg_i,
  output logic [3:0] px_o,
  output logic       opq_o
);

  logic [7:0] sreg_q, sreg_d;
  logic       sel_q, sel_d;
  logic [3:0] px_q, px_d;
  logic       opq_q, opq_d;

  // A load on the last pixel of a tile replaces that pixel's shift; the MSB is still emitted.
  always_comb begin
    sreg_d = 8'd0;
    sel_d  = sel_q;
    px_d   = 4'd0;
    opq_d  = 1'b0;
    if (load_i) begin
      sreg_d = pattern_i;
      sel_d  = sel_i;
    end else if (shift_i) begin
      sreg_d = {sreg_q[6:0], 1'b0};
    end
    if (shift_i) begin
      px_d  = pickColour(sreg_q[7], sel_q, fgA_i, fgB_i, bg_i);
      opq_d = sreg_q[7] & bgEn_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sreg_q <= 8'd0;
      sel_q  <= 1'b0;
      px_q   <= 4'd0;
      opq_q  <= 1'b0;
    end else if (ce_i) begin
      sreg_q <= sreg_d;
      sel_q  <= sel_d;
      px_q   <= px_d;
      opq_q  <= opq_d;
    end
  end

  assign px_o  = px_q;
  assign opq_o = opq_q;

endmodule

// File: rtl/epochtv1_bgfetch.sv
// Background tile fetcher: reads map and pattern bytes one tile ahead of the beam
// and hands each 8-pixel pattern to the serialiser at the tile boundary.
module epochtv1_bgfetch
  import epochtv1_pkg::*;
#(
  parameter logic [8:0] FIRST_ROW_RENDER = FIRST_ROW_RENDER_DEF,
  parameter logic [8:0] NUM_RENDER_ROWS  = NUM_RENDER_ROWS_DEF,
  parameter logic [8:0] FIRST_COL_RENDER = FIRST_COL_RENDER_DEF,
  parameter logic [8:0] NUM_RENDER_COLS  = NUM_RENDER_COLS_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic [8:0] ROW,
  input  logic [8:0] COL,
  input  logic       BG_EN,
  input  logic [3:0] CLR_FG_A,
  input  logic [3:0] CLR_FG_B,
  input  logic [3:0] CLR_BG,
  output logic [8:0] BGM_A,
  input  logic [7:0] BGM_D,
  output logic [9:0] CHR_A,
  input  logic [7:0] CHR_D,
  output logic [3:0] PX,
  output logic       OPQ
);

  localparam logic [8:0] FETCH_START = FIRST_COL_RENDER - FETCH_LEAD;
  localparam logic [8:0] ACTIVE_END  = FIRST_COL_RENDER + NUM_RENDER_COLS;
  localparam logic [8:0] ROW_END     = FIRST_ROW_RENDER + NUM_RENDER_ROWS;
  localparam logic [4:0] LAST_TX     = 5'((NUM_RENDER_COLS >> 3) - 9'd1);

  bgFetchState_e state_q, state_d;
  logic [8:0] bgmAddr_q, bgmAddr_d;
  logic [9:0] chrAddr_q, chrAddr_d;
  logic       mapSel_q, mapSel_d;
  logic [7:0] pendPat_q, pendPat_d;
  logic       pendSel_q, pendSel_d;
  logic       lineOk_q, lineOk_d;
  logic       loadTile;

  logic [8:0] rowRel, colRel;
  logic [3:0] tileY;
  logic [2:0] patRow, phase;
  logic [4:0] tileX;
  logic       renderRow, activeCol, shiftEn, fetchStart;
  bgmEntry_t  bgmWord;

  assign rowRel     = ROW - FIRST_ROW_RENDER;
  assign colRel     = COL - FETCH_START;
  assign tileY      = 4'(rowRel >> 4);
  assign patRow     = 3'(rowRel >> 1);
  assign tileX      = 5'(colRel >> 3);
  assign phase      = colRel[2:0];
  assign renderRow  = (ROW >= FIRST_ROW_RENDER) && (ROW < ROW_END);
  assign activeCol  = (COL >= FIRST_COL_RENDER) && (COL < ACTIVE_END);
  assign fetchStart = (state_q == IDLE) && renderRow && (COL == FETCH_START);
  assign shiftEn    = renderRow && activeCol && lineOk_q;
  assign bgmWord    = BGM_D;

  // Each state's work lands on the CE edge that leaves it, so the ROM data
  // sampled there belongs to the address registered one edge earlier.
  always_comb begin
    state_d   = state_q;
    bgmAddr_d = bgmAddr_q;
    chrAddr_d = chrAddr_q;
    mapSel_d  = mapSel_q;
    pendPat_d = pendPat_q;
    pendSel_d = pendSel_q;
    loadTile  = 1'b0;
    case (state_q)
      IDLE: if (fetchStart) state_d = MAP;
      MAP: begin
        bgmAddr_d = {tileY, tileX};
        state_d   = CHR;
      end
      CHR: begin
        mapSel_d  = bgmWord.sel;
        chrAddr_d = {bgmWord.code, patRow};
        state_d   = LATCH;
      end
      LATCH: begin
        pendPat_d = CHR_D;
        pendSel_d = mapSel_q;
        state_d   = WAIT;
      end
      WAIT: begin
        if (phase == 3'd7) begin
          loadTile = 1'b1;
          state_d  = (tileX < LAST_TX) ? MAP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A line only renders if its fetch began cleanly; a mid-line reset blanks the rest of it.
  always_comb begin
    lineOk_d = lineOk_q;
    if (fetchStart) lineOk_d = 1'b1;
    else if (!renderRow || (COL == ACTIVE_END)) lineOk_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      bgmAddr_q <= 9'd0;
      chrAddr_q <= 10'd0;
      mapSel_q  <= 1'b0;
      pendPat_q <= 8'd0;
      pendSel_q <= 1'b0;
      lineOk_q  <= 1'b0;
    end else if (CE) begin
      state_q   <= state_d;
      bgmAddr_q <= bgmAddr_d;
      chrAddr_q <= chrAddr_d;
      mapSel_q  <= mapSel_d;
      pendPat_q <= pendPat_d;
      pendSel_q <= pendSel_d;
      lineOk_q  <= lineOk_d;
    end
  end

  assign BGM_A = bgmAddr_q;
  assign CHR_A = chrAddr_q;

  epochtv1_bg_sreg u_sreg (
    .clk_i    (CLK),
    .rst_i    (RST),
    .ce_i     (CE),
    .load_i   (loadTile),
    .pattern_i(pendPat_q),
    .sel_i    (pendSel_q),
    .shift_i  (shiftEn),
    .bgEn_i   (BG_EN),
    .fgA_i    (CLR_FG_A),
    .fgB_i    (CLR_FG_B),
    .bg_i     (CLR_BG),
    .px_o     (PX),
    .opq_o    (OPQ)
  );

endmodule

// File: tb/tb_epochtv1_bgfetch.sv
// Bench for epochtv1_bgfetch: directed scenarios plus a random full frame against a pixel model.
module tb_epochtv1_bgfetch;

  logic       clk = 1'b0;
  logic       rst, ce, bgEn;
  logic [8:0] row, col;
  logic [3:0] fgA, fgB, bgClr;
  logic [8:0] bgmA;
  logic [7:0] bgmD;
  logic [9:0] chrA;
  logic [7:0] chrD;
  logic [3:0] px;
  logic       opq;

  logic [7:0] bgm [0:511];
  logic [7:0] chr [0:1023];

  int testsRun = 0;
  int testsFailed = 0;

  bit         modelLineOk;
  logic [3:0] expPx;
  logic       expOpq;
  logic [3:0] capPx [0:259];
  logic       capOpq [0:259];

  logic [3:0] pxTab [8] = '{4'd4, 4'd1, 4'd4, 4'd1, 4'd1, 4'd4, 4'd1, 4'd4};
  logic       opqTab [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  assign bgmD = bgm[bgmA];
  assign chrD = chr[chrA];

  epochtv1_bgfetch dut (
    .CLK     (clk),
    .RST     (rst),
    .CE      (ce),
    .ROW     (row),
    .COL     (col),
    .BG_EN   (bgEn),
    .CLR_FG_A(fgA),
    .CLR_FG_B(fgB),
    .CLR_BG  (bgClr),
    .BGM_A   (bgmA),
    .BGM_D   (bgmD),
    .CHR_A   (chrA),
    .CHR_D   (chrD),
    .PX      (px),
    .OPQ     (opq)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Pixel for a render-window coordinate, straight from map/pattern/colour rules.
  function automatic logic [4:0] modelPixel(input int r, input int c);
    int rr, ty, py, tx;
    logic [7:0] entry, pat;
    logic b;
    logic [3:0] colour;
    rr = r - 21;
    ty = rr / 16;
    py = (rr % 16) / 2;
    tx = (c - 28) / 8;
    entry = bgm[ty * 32 + tx];
    pat = chr[int'(entry[6:0]) * 8 + py];
    b = pat[7 - ((c - 28) % 8)];
    colour = b ? (entry[7] ? fgB : fgA) : bgClr;
    return {b & bgEn, colour};
  endfunction

  task automatic modelStep(input int r, input int c, input bit rstIn);
    bit renderRow;
    logic [4:0] p;
    renderRow = (r >= 21) && (r < 243);
    expPx = 4'd0;
    expOpq = 1'b0;
    if (rstIn) begin
      modelLineOk = 1'b0;
    end else begin
      if (renderRow && c == 20) modelLineOk = 1'b1;
      if (renderRow && modelLineOk && c >= 28 && c < 220) begin
        p = modelPixel(r, c);
        expPx = p[3:0];
        expOpq = p[4];
      end
      if (!renderRow || c == 220) modelLineOk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input bit rstIn, input int gap);
    @(negedge clk);
    row = 9'(r);
    col = 9'(c);
    rst = rstIn;
    ce = 1'b1;
    modelStep(r, c, rstIn);
    @(posedge clk);
    #1;
    checkOutput($sformatf("px r%0d c%0d", r, c), 16'(px), 16'(expPx));
    checkOutput($sformatf("opq r%0d c%0d", r, c), 16'(opq), 16'(expOpq));
    capPx[c] = px;
    capOpq[c] = opq;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      ce = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold px r%0d c%0d", r, c), 16'(px), 16'(expPx));
      checkOutput($sformatf("hold opq r%0d c%0d", r, c), 16'(opq), 16'(expOpq));
    end
  endtask

  // gapMode < 0 picks an occasional random one-cycle CE stall.
  task automatic runRow(input int r, input int gapMode, input int rstCol);
    int g;
    for (int c = 0; c < 260; c++) begin
      g = (gapMode < 0) ? (($urandom_range(0, 15) == 0) ? 1 : 0) : gapMode;
      applyStimulus(r, c, (c == rstCol), g);
    end
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b0;
    row = 9'd0;
    col = 9'd0;
    bgEn = 1'b1;
    fgA = 4'd4;
    fgB = 4'd9;
    bgClr = 4'd1;
    modelLineOk = 1'b0;
    for (int i = 0; i < 512; i++) bgm[i] = 8'h00;
    for (int i = 0; i < 1024; i++) chr[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset px", 16'(px), 16'd0);
    checkOutput("reset opq", 16'(opq), 16'd0);
    checkOutput("reset bgm_a", 16'(bgmA), 16'd0);
    checkOutput("reset chr_a", 16'(chrA), 16'd0);
    @(negedge clk);
    ce = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset with ce px", 16'(px), 16'd0);
    checkOutput("reset with ce bgm_a", 16'(bgmA), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    ce = 1'b0;

    // Basic tile at the top-left corner.
    bgm[0] = 8'h05;
    chr[5 * 8 + 0] = 8'hA5;
    runRow(20, 0, -1);
    runRow(21, 0, -1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("s1 px c%0d", 28 + i), 16'(capPx[28 + i]), 16'(pxTab[i]));
      checkOutput($sformatf("s1 opq c%0d", 28 + i), 16'(capOpq[28 + i]), 16'(opqTab[i]));
    end

    // Last tile of a line with colour pair B.
    bgm[2 * 32 + 23] = 8'h83;
    chr[3 * 8 + 5] = 8'hFF;
    fgB = 4'd12;
    runRow(63, 0, -1);
    for (int c = 212; c < 220; c++) begin
      checkOutput($sformatf("s2 px c%0d", c), 16'(capPx[c]), 16'd12);
      checkOutput($sformatf("s2 opq c%0d", c), 16'(capOpq[c]), 16'd1);
    end
    checkOutput("s2 px c220", 16'(capPx[220]), 16'd0);
    checkOutput("s2 opq c220", 16'(capOpq[220]), 16'd0);

    // Background disabled keeps colours but drops opacity.
    bgEn = 1'b0;
    runRow(21, 0, -1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("s3 px c%0d", 28 + i), 16'(capPx[28 + i]), 16'(pxTab[i]));
      checkOutput($sformatf("s3 opq c%0d", 28 + i), 16'(capOpq[28 + i]), 16'd0);
    end

    // CE stalls of three cycles between every enable.
    bgEn = 1'b1;
    runRow(21, 3, -1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("s4 px c%0d", 28 + i), 16'(capPx[28 + i]), 16'(pxTab[i]));
      checkOutput($sformatf("s4 opq c%0d", 28 + i), 16'(capOpq[28 + i]), 16'(opqTab[i]));
    end

    // Mid-line reset blanks the rest of the line; the next row recovers.
    runRow(21, 0, 100);
    checkOutput("s5 px after reset", 16'(capPx[150]), 16'd0);
    checkOutput("s5 opq after reset", 16'(capOpq[150]), 16'd0);
    runRow(22, 0, -1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("s5 row22 px c%0d", 28 + i), 16'(capPx[28 + i]), 16'(pxTab[i]));
    end

    // Random full frame.
    for (int i = 0; i < 512; i++) bgm[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) chr[i] = 8'($urandom);
    fgA = 4'($urandom);
    fgB = 4'($urandom);
    bgClr = 4'($urandom);
    for (int r = 0; r < 262; r++) begin
      bgEn = ($urandom_range(0, 3) != 0);
      runRow(r, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
